// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings and default widths for the IF/MEM memory-port arbiter.
package mem_port_arbiter_pkg;

  // Default bus widths and starvation limit.
  localparam int unsigned DefDataWidth = 32;
  localparam int unsigned DefAddrWidth = 32;
  localparam int unsigned DefMaxIfWait = 4;
  localparam int unsigned DefCntWidth  = 3;

  // FSM state encodings. These are plain constants so that legacy code can
  // still compare against them as bit patterns.
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_BUSY_IF = 2'd1;
  localparam logic [1:0] ST_BUSY_D  = 2'd2;
  localparam logic [1:0] ST_RESP    = 2'd3;

  // Which requester the access that just finished belonged to.
  typedef enum logic [1:0] {
    SrvNone = 2'd0,
    SrvIf   = 2'd1,
    SrvD    = 2'd2
  } served_e;

  // Map a busy state onto the requester it is serving.
  function automatic served_e served_of(input logic [1:0] st);
    served_e id;
    id = SrvNone;
    if (st == ST_BUSY_IF) begin
      id = SrvIf;
    end else if (st == ST_BUSY_D) begin
      id = SrvD;
    end
    return id;
  endfunction

endpackage

// File: rtl/arb_starvation_select.sv
// Grant selection between fetch and data requests. Data wins by default; a
// counter of data grants taken while fetch was waiting forces a fetch grant
// once it reaches MAX_IF_WAIT.
module arb_starvation_select
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned MAX_IF_WAIT = DefMaxIfWait,
  parameter int unsigned CNT_WIDTH   = DefCntWidth
) (
  input  logic clk,
  input  logic rst,
  input  logic grant_en,
  input  logic if_req,
  input  logic d_req,
  output logic grant_if,
  output logic grant_d
);

  localparam logic [CNT_WIDTH-1:0] MaxCnt = CNT_WIDTH'(MAX_IF_WAIT);

  logic [CNT_WIDTH-1:0] count_q, count_d;

  // Pick a winner; only meaningful while the arbiter is idle.
  always_comb begin
    grant_if = 1'b0;
    grant_d  = 1'b0;
    if (grant_en) begin
      if (if_req && d_req) begin
        if (count_q == MaxCnt) begin
          grant_if = 1'b1;
        end else begin
          grant_d = 1'b1;
        end
      end else if (if_req) begin
        grant_if = 1'b1;
      end else if (d_req) begin
        grant_d = 1'b1;
      end
    end
  end

  // Count data grants that overtook a pending fetch; a fetch grant clears it.
  always_comb begin
    count_d = count_q;
    if (grant_if) begin
      count_d = '0;
    end else if (grant_d && if_req && (count_q != MaxCnt)) begin
      count_d = count_q + CNT_WIDTH'(1);
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the instruction-fetch and data-memory
// stages. One access at a time: IDLE grants, BUSY_x waits for the memory,
// RESP releases the stall of the served requester for exactly one cycle.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DefDataWidth,
  parameter int unsigned ADDR_WIDTH  = DefAddrWidth,
  parameter int unsigned MAX_IF_WAIT = DefMaxIfWait,
  parameter int unsigned CNT_WIDTH   = DefCntWidth
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  IF_REQ,
  input  logic [ADDR_WIDTH-1:0] IF_ADDRESS,
  output logic [DATA_WIDTH-1:0] IF_READ_DATA,
  output logic                  IF_BUSYWAIT,
  input  logic                  D_READ,
  input  logic                  D_WRITE,
  input  logic [ADDR_WIDTH-1:0] D_ADDRESS,
  input  logic [DATA_WIDTH-1:0] D_WRITE_DATA,
  output logic [DATA_WIDTH-1:0] D_READ_DATA,
  output logic                  D_BUSYWAIT,
  output logic                  MEM_READ,
  output logic                  MEM_WRITE,
  output logic [ADDR_WIDTH-1:0] MEM_ADDRESS,
  output logic [DATA_WIDTH-1:0] MEM_WRITE_DATA,
  input  logic [DATA_WIDTH-1:0] MEM_READ_DATA,
  input  logic                  MEM_BUSYWAIT
);

  logic [1:0]            state_q, state_d;
  served_e               served_q, served_d;
  logic                  mem_read_q, mem_read_d;
  logic                  mem_write_q, mem_write_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;

  logic d_req;
  logic grant_if, grant_d;

  assign d_req = D_READ | D_WRITE;

  arb_starvation_select #(
    .MAX_IF_WAIT(MAX_IF_WAIT),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_select (
    .clk     (CLK),
    .rst     (RESET),
    .grant_en(state_q == ST_IDLE),
    .if_req  (IF_REQ),
    .d_req   (d_req),
    .grant_if(grant_if),
    .grant_d (grant_d)
  );

  // Next-state and datapath: latch the winner's command, then wait for memory.
  always_comb begin
    state_d     = state_q;
    served_d    = served_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (grant_if) begin
          state_d     = ST_BUSY_IF;
          mem_addr_d  = IF_ADDRESS;
          mem_read_d  = 1'b1;
          mem_write_d = 1'b0;
        end else if (grant_d) begin
          state_d    = ST_BUSY_D;
          mem_addr_d = D_ADDRESS;
          // A simultaneous read and write is treated as a write.
          if (D_WRITE) begin
            mem_write_d = 1'b1;
            mem_read_d  = 1'b0;
            mem_wdata_d = D_WRITE_DATA;
          end else begin
            mem_read_d  = 1'b1;
            mem_write_d = 1'b0;
          end
        end
      end

      ST_BUSY_IF, ST_BUSY_D: begin
        if (!MEM_BUSYWAIT) begin
          if (state_q == ST_BUSY_IF) begin
            if_rdata_d = MEM_READ_DATA;
          end else if (mem_read_q) begin
            d_rdata_d = MEM_READ_DATA;
          end
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          served_d    = served_of(state_q);
          state_d     = ST_RESP;
        end
      end

      ST_RESP: begin
        state_d  = ST_IDLE;
        served_d = SrvNone;
      end

      default: begin
        state_d  = ST_IDLE;
        served_d = SrvNone;
      end
    endcase
  end

  // State and datapath registers; reset abandons any in-flight access.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      served_q    <= SrvNone;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      served_q    <= served_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign MEM_READ       = mem_read_q;
  assign MEM_WRITE      = mem_write_q;
  assign MEM_ADDRESS    = mem_addr_q;
  assign MEM_WRITE_DATA = mem_wdata_q;
  assign IF_READ_DATA   = if_rdata_q;
  assign D_READ_DATA    = d_rdata_q;

  // Stall every requester except the one being released this cycle.
  assign IF_BUSYWAIT = IF_REQ & ~((state_q == ST_RESP) && (served_q == SrvIf));
  assign D_BUSYWAIT  = d_req & ~((state_q == ST_RESP) && (served_q == SrvD));

endmodule
